// File: rtl/sdm_stream_pkg.sv
// Shared types, command/ASCII constants and the nibble formatter for the
// ADC sample hex streamer.
package sdm_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam logic [7:0] CMD_START_L = 8'h73;
  localparam logic [7:0] CMD_START_U = 8'h53;
  localparam logic [7:0] CMD_ABORT_L = 8'h78;
  localparam logic [7:0] CMD_ABORT_U = 8'h58;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy count and flush.
// rd_valid marks rd_data as the current head (it lags a push or pop by one clock).
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      rd_valid <= (count != '0) && !pop;
    end
  end

endmodule

// File: rtl/sample_hex_streamer.sv
// Captures a burst of ADC samples into a FIFO and streams each one out as an
// uppercase hex line terminated by LF CR, under 's'/'x' command control.
module sample_hex_streamer
  import sdm_stream_pkg::*;
#(
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int BURST_LEN   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [SAMPLE_BITS-1:0] s_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_data,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int NIBBLES = SAMPLE_BITS / 4;
  localparam int PW      = $clog2(NIBBLES + 2);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int BW      = $clog2(BURST_LEN + 1);

  state_t                 state;
  logic [PW-1:0]          pos;
  logic                   last_nib;
  logic                   cr_cur;
  logic                   abort_pending;
  logic [BW-1:0]          burst_cnt;

  logic [SAMPLE_BITS-1:0] fifo_data;
  logic                   fifo_rd_valid;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_flush;

  logic [3:0]             nibble [NIBBLES];
  logic [3:0]             cur_nib;

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign nibble[gi] = fifo_data[SAMPLE_BITS-1-4*gi -: 4];
    end
  endgenerate

  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (pos == PW'(i)) cur_nib = nibble[i];
    end
  end

  logic cmd_accept, is_start, is_abort, aborting, abort_done;
  logic handshake, load, sample_in, room, drain_done;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign is_start   = cmd_accept && (cmd_data == CMD_START_L || cmd_data == CMD_START_U);
  assign is_abort   = cmd_accept && (cmd_data == CMD_ABORT_L || cmd_data == CMD_ABORT_U);
  assign aborting   = (state != ST_IDLE) && (abort_pending || is_abort);
  // An abort waits only for a byte already on the bus to be taken.
  assign abort_done = aborting && (!m_valid || m_ready);
  assign handshake  = m_valid && m_ready;
  assign load       = !m_valid || m_ready;
  assign fifo_pop   = handshake && last_nib && !abort_done;
  assign sample_in  = (state == ST_CAPTURE) && s_valid && !aborting;
  assign room       = (fifo_count < CW'(FIFO_DEPTH)) || fifo_pop;
  assign fifo_push  = sample_in && room;
  assign fifo_flush = abort_done;
  assign drain_done = (state == ST_DRAIN) && (fifo_count == '0) &&
                      ((handshake && cr_cur) || (!m_valid && pos == '0));
  assign busy       = (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .wr_data  (s_data),
    .pop      (fifo_pop),
    .rd_data  (fifo_data),
    .rd_valid (fifo_rd_valid),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      pos           <= '0;
      last_nib      <= 1'b0;
      cr_cur        <= 1'b0;
      abort_pending <= 1'b0;
      burst_cnt     <= '0;
      overflow      <= 1'b0;
      drop_count    <= '0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      cmd_ready     <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      case (state)
        ST_IDLE: begin
          m_valid       <= 1'b0;
          pos           <= '0;
          last_nib      <= 1'b0;
          cr_cur        <= 1'b0;
          abort_pending <= 1'b0;
          if (is_start) begin
            state      <= ST_CAPTURE;
            burst_cnt  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
          end
        end
        default: begin
          if (sample_in) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (!room) begin
              overflow <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            if (burst_cnt == BW'(BURST_LEN - 1)) state <= ST_DRAIN;
          end
          if (load) begin
            if (pos < PW'(NIBBLES)) begin
              cr_cur <= 1'b0;
              if (fifo_rd_valid) begin
                m_valid  <= 1'b1;
                m_data   <= nib_to_ascii(cur_nib);
                last_nib <= (pos == PW'(NIBBLES - 1));
                pos      <= pos + 1'b1;
              end else begin
                m_valid  <= 1'b0;
                last_nib <= 1'b0;
              end
            end else if (pos == PW'(NIBBLES)) begin
              m_valid  <= 1'b1;
              m_data   <= ASCII_LF;
              last_nib <= 1'b0;
              cr_cur   <= 1'b0;
              pos      <= pos + 1'b1;
            end else begin
              m_valid  <= 1'b1;
              m_data   <= ASCII_CR;
              last_nib <= 1'b0;
              cr_cur   <= 1'b1;
              pos      <= '0;
            end
          end
          if (is_abort) abort_pending <= 1'b1;
          if (drain_done) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
          end
          if (abort_done) begin
            state         <= ST_IDLE;
            m_valid       <= 1'b0;
            pos           <= '0;
            last_nib      <= 1'b0;
            cr_cur        <= 1'b0;
            abort_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_hex_streamer.sv
// Directed bench for sample_hex_streamer: expected ASCII bytes are queued as
// samples are driven and compared as the DUT hands them over.
module tb_sample_hex_streamer;

  localparam int SB  = 24;
  localparam int FD  = 4;
  localparam int BL  = 12;
  localparam int NIB = SB / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [SB-1:0] s_data = '0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_data = '0;
  logic          m_ready = 1'b0;
  logic          cmd_ready;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  sample_hex_streamer #(
    .SAMPLE_BITS (SB),
    .FIFO_DEPTH  (FD),
    .BURST_LEN   (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  logic [7:0] exp_q [$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         model_cnt = 0;
  int         rx_idx    = 0;
  int         rx_total  = 0;
  bit         toggle_mode = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic model_sample(input logic [SB-1:0] v);
    if (model_cnt < FD) begin
      for (int i = NIB - 1; i >= 0; i--) exp_q.push_back(hexc(v[4*i +: 4]));
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0D);
      model_cnt++;
    end
  endtask

  // One clock: observe the handshake at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (prev_hold && !rst) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    prev_hold = m_valid && !m_ready && !rst;
    prev_data = m_data;
    if (m_valid && m_ready && !rst) begin
      chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("rx byte %02h expected %02h", m_data, e);
        chk("rx_byte", 32'(m_data), 32'(e));
        rx_idx++;
        rx_total++;
        if (rx_idx == NIB) model_cnt--;
        if (rx_idx == NIB + 2) rx_idx = 0;
      end
    end
    @(posedge clk);
    #1;
    if (toggle_mode) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_valid = 1'b1;
    cmd_data  = c;
    $display("cmd %02h", c);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [SB-1:0] v);
    s_valid = 1'b1;
    s_data  = v;
    model_sample(v);
    $display("sample %06h", v);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_cnt = 0;
    rx_idx    = 0;
  endtask

  initial begin
    logic [7:0] e;
    int         rx_start;

    // Reset state
    repeat (2) tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Single sample, latency and byte sequence
    m_ready = 1'b1;
    send_cmd(8'h73);
    chk("start_busy", 32'(busy), 32'd1);
    send_sample(24'h0A3F5C);
    chk("lat_k0", 32'(m_valid), 32'd0);
    tick();
    chk("lat_k1", 32'(m_valid), 32'd0);
    tick();
    chk("lat_k2", 32'(m_valid), 32'd1);
    chk("lat_first_char", 32'(m_data), 32'h30);
    wait_drain(30);
    chk("single_overflow", 32'(overflow), 32'd0);
    send_cmd(8'h78);
    chk("single_abort_idle", 32'(busy), 32'd0);
    reset_model();

    // Start ignored in CAPTURE, other bytes ignored in IDLE
    send_cmd(8'h53);
    send_cmd(8'h73);
    chk("restart_ignored_busy", 32'(busy), 32'd1);
    chk("restart_cmd_ready", 32'(cmd_ready), 32'd1);
    send_sample(24'hFEDCBA);
    wait_drain(30);
    send_cmd(8'h58);
    chk("abort_upper_idle", 32'(busy), 32'd0);
    send_cmd(8'h71);
    chk("q_ignored_busy", 32'(busy), 32'd0);
    chk("q_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) tick();
    reset_model();

    // Full burst, spaced samples
    rx_start = rx_total;
    send_cmd(8'h73);
    for (int i = 1; i <= BL; i++) begin
      send_sample(SB'(i));
      if (i < BL) repeat (19) tick();
    end
    chk("burst_drain_busy", 32'(busy), 32'd1);
    wait_drain(60);
    chk("burst_idle_after_cr", 32'(busy), 32'd0);
    chk("burst_overflow", 32'(overflow), 32'd0);
    chk("burst_bytes", 32'(rx_total - rx_start), 32'(BL * (NIB + 2)));
    reset_model();

    // Overflow with the output stalled
    m_ready = 1'b0;
    send_cmd(8'h73);
    for (int i = 0; i < 10; i++) send_sample(SB'(24'h100000 + i * 24'h011111));
    chk("ovf_drop_count", 32'(drop_count), 32'd6);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    rx_start = rx_total;
    m_ready = 1'b1;
    wait_drain(100);
    repeat (10) tick();
    chk("ovf_lines_bytes", 32'(rx_total - rx_start), 32'(FD * (NIB + 2)));
    send_cmd(8'h78);
    chk("ovf_abort_idle", 32'(busy), 32'd0);
    reset_model();

    // Abort mid-line with m_ready toggling
    toggle_mode = 1'b1;
    send_cmd(8'h53);
    send_sample(24'hABCDEF);
    send_sample(24'h123456);
    for (int i = 0; i < 200 && rx_idx < 3; i++) tick();
    chk("midline_reached", 32'(rx_idx >= 3), 32'd1);
    if (m_valid) begin
      e = exp_q[0];
      exp_q.delete();
      exp_q.push_back(e);
    end else begin
      exp_q.delete();
    end
    send_cmd(8'h78);
    repeat (40) tick();
    chk("abort_inflight_done", 32'(exp_q.size()), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    toggle_mode = 1'b0;
    m_ready = 1'b1;
    reset_model();
    send_cmd(8'h73);
    repeat (20) tick();
    send_cmd(8'h78);
    chk("abort_fifo_empty_idle", 32'(busy), 32'd0);
    reset_model();

    // Reset during DRAIN
    m_ready = 1'b0;
    send_cmd(8'h73);
    for (int i = 1; i <= BL; i++) send_sample(SB'(i * 24'h000101));
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_drop_count", 32'(drop_count), 32'(BL - FD));
    rst = 1'b1;
    prev_hold = 1'b0;
    #1;
    chk("rst_drain_m_valid", 32'(m_valid), 32'd0);
    chk("rst_drain_m_data", 32'(m_data), 32'd0);
    chk("rst_drain_busy", 32'(busy), 32'd0);
    chk("rst_drain_overflow", 32'(overflow), 32'd0);
    chk("rst_drain_drop", 32'(drop_count), 32'd0);
    chk("rst_drain_cmd_ready", 32'(cmd_ready), 32'd0);
    reset_model();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    m_ready = 1'b1;
    send_cmd(8'h73);
    chk("clean_start_busy", 32'(busy), 32'd1);
    chk("clean_start_drop", 32'(drop_count), 32'd0);
    chk("clean_start_overflow", 32'(overflow), 32'd0);
    repeat (20) tick();
    send_sample(24'h00F00D);
    wait_drain(30);
    send_cmd(8'h78);
    chk("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sample_hex_streamer.md
SAMPLE_HEX_STREAMER -- requirements
Module: sample_hex_streamer

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 24, meaning ADC sample width; must be a multiple of 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning sample FIFO entries; must be a power of 2.
REQ-003 SHALL have parameter BURST_LEN, default 1024, meaning samples counted per capture burst.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_valid  in  1  sample strobe from sigma_delta_adc adc_valid; there is no back-pressure.
REQ-007 SHALL have port s_data  in  SAMPLE_BITS  sample value from adc_output.
REQ-008 SHALL have port cmd_valid  in  1  command byte strobe from uart rvalid.
REQ-009 SHALL have port cmd_ready  out  1  command accept, held at 1 outside reset.
REQ-010 SHALL have port cmd_data  in  8  command byte.
REQ-011 SHALL have port m_valid  out  1  ASCII byte valid, to uart tvalid.
REQ-012 SHALL have port m_ready  in  1  ASCII byte accept, from uart tready.
REQ-013 SHALL have port m_data  out  8  ASCII byte.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port overflow  out  1  sticky flag set when a sample is dropped during the current or most recent burst.
REQ-016 SHALL have port drop_count  out  16  count of dropped samples, saturating at 0xFFFF.

Function
REQ-017 SHALL implement the states IDLE, CAPTURE and DRAIN.
REQ-018 SHALL treat a command as accepted on any cycle with cmd_valid&cmd_ready.
REQ-019 In IDLE, 's' (0x73) or 'S' (0x53) SHALL move the block to CAPTURE and clear the burst counter, overflow and drop_count.
REQ-020 SHALL ignore 's'/'S' received in CAPTURE or DRAIN, and SHALL ignore every byte other than the start and abort bytes.
REQ-021 'x' (0x78) or 'X' (0x58) in CAPTURE or DRAIN SHALL cause a flush of the FIFO and a return to IDLE.
REQ-022 The flush SHALL occur on the first cycle with m_valid low, or immediately after the current m_valid&m_ready handshake.
REQ-023 No partial sample line SHALL be emitted after an abort.
REQ-024 In CAPTURE, each s_valid SHALL increment the burst counter.
REQ-025 In CAPTURE, each s_valid SHALL push s_data when FIFO count < FIFO_DEPTH or a pop occurs in the same cycle.
REQ-026 A sample that cannot be pushed SHALL be dropped; overflow SHALL be set and drop_count incremented, saturating.
REQ-027 s_valid outside CAPTURE SHALL be ignored.
REQ-028 When the burst counter reaches BURST_LEN, the block SHALL enter DRAIN and accept no further pushes.
REQ-029 DRAIN SHALL go to IDLE on the cycle after the FIFO is empty and the CR of the last line is accepted.
REQ-030 Each popped sample SHALL produce, in order, SAMPLE_BITS/4 uppercase hex characters MSB-first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0A, then 0x0D.
REQ-031 Once m_valid is asserted, m_valid and m_data SHALL remain stable until m_ready.
REQ-032 Throughput SHALL be one byte per cycle while m_ready=1, including across sample boundaries.
REQ-033 The FIFO pop SHALL coincide with acceptance of the final nibble character.
REQ-034 Latency SHALL be 2 clocks: a sample pushed into an empty FIFO at edge k makes m_valid high after edge k+2.
REQ-035 Burst counting SHALL include dropped samples, so that exactly BURST_LEN ADC periods are spanned.

Reset
REQ-036 On rst, the block SHALL asynchronously enter IDLE with the FIFO empty and all counters zero.
REQ-037 During rst, m_valid=0, m_data=0, busy=0, overflow=0, drop_count=0 and cmd_ready=0; cmd_ready SHALL be 1 from the first clock after deassertion.
REQ-038 Reset mid-burst SHALL discard all state; no further bytes SHALL be emitted until a new 's'.

Structure
REQ-039 Package sdm_stream_pkg SHALL hold the state enum, the constants CMD_START_L/U, CMD_ABORT_L/U, ASCII_LF and ASCII_CR, and the nibble-to-ASCII function.
REQ-040 The FIFO SHALL be the sub-module sync_fifo (parameterised width/depth, registered read, count, flush input).
REQ-041 Formatting and control SHALL reside in sample_hex_streamer.

Verification
REQ-042 Send 's', one sample 0x0A3F5C with m_ready=1 -> bytes 30 41 33 46 35 43 0A 0D; m_valid rises 2 clocks after s_valid.
REQ-043 Run BURST_LEN=4, samples 1..4 every 20 clocks -> 32 bytes emitted, busy falls after the last 0x0D, overflow=0.
REQ-044 Run FIFO_DEPTH=4, m_ready=0, 10 samples -> 4 stored, drop_count=6, overflow=1; releasing m_ready emits exactly 4 lines.
REQ-045 Send 'x' mid-line with m_ready toggling -> the in-flight byte completes, then no more bytes follow and the block is IDLE with the FIFO empty.
REQ-046 Assert rst during DRAIN -> all outputs 0 immediately; 's' after reset starts a clean burst with drop_count=0.
REQ-047 Send 's' during CAPTURE and 'q' in IDLE -> no state change; cmd_ready stays 1.
